// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds renamed ALU micro-ops until both operands are present,
// then issues the lowest-index ready entry. Wakeup comes from dispatch-time values or the CDB.
package alu_rs_pkg;
  typedef enum logic [1:0] {
    AluPlus  = 2'd0,
    AluMinus = 2'd1,
    AluAnd   = 2'd2,
    AluXor   = 2'd3
  } alu_op_t;
endpackage

module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_flush,
  input  logic              in_disp_valid,
  output logic              out_disp_ready,
  input  alu_op_t           in_disp_alu_op,
  input  logic              in_disp_set_cc,
  input  logic              in_disp_valb_sel,
  input  logic [DATA_W-1:0] in_disp_imm,
  input  logic              in_disp_rdy_a,
  input  logic              in_disp_rdy_b,
  input  logic [DATA_W-1:0] in_disp_val_a,
  input  logic [DATA_W-1:0] in_disp_val_b,
  input  logic [TAG_W-1:0]  in_disp_tag_a,
  input  logic [TAG_W-1:0]  in_disp_tag_b,
  input  logic [TAG_W-1:0]  in_disp_dst_tag,
  input  logic              in_cdb_valid,
  input  logic [TAG_W-1:0]  in_cdb_tag,
  input  logic [DATA_W-1:0] in_cdb_val,
  output logic              out_issue_valid,
  input  logic              in_issue_ready,
  output alu_op_t           out_issue_alu_op,
  output logic [DATA_W-1:0] out_issue_val_a,
  output logic [DATA_W-1:0] out_issue_val_b,
  output logic [TAG_W-1:0]  out_issue_dst_tag,
  output logic              out_issue_set_cc
);

  localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic              valid;
    alu_op_t           alu_op;
    logic              set_cc;
    logic [TAG_W-1:0]  dst_tag;
    logic              rdy_a;
    logic              rdy_b;
    logic [TAG_W-1:0]  tag_a;
    logic [TAG_W-1:0]  tag_b;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
  } entry_t;

  entry_t [ENTRIES-1:0] ent_q, ent_d;
  entry_t               disp_ent;
  logic [ENTRIES-1:0]   valid_vec;
  logic                 sel_found;
  logic [IdxW-1:0]      sel_idx;
  logic [IdxW-1:0]      free_idx;
  logic                 disp_fire;
  logic                 cdb_hit_a, cdb_hit_b;

  // Priority encoders: lowest-index candidate and lowest-index free slot.
  always_comb begin
    valid_vec = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      valid_vec[i] = ent_q[i].valid;
      if (ent_q[i].valid && ent_q[i].rdy_a && ent_q[i].rdy_b) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
      if (!ent_q[i].valid) begin
        free_idx = IdxW'(i);
      end
    end
  end

  // occupancy < ENTRIES is equivalent to at least one registered slot being free.
  assign out_disp_ready  = ~&valid_vec;
  assign out_issue_valid = sel_found && !in_flush;

  always_comb begin
    out_issue_alu_op  = AluPlus;
    out_issue_val_a   = '0;
    out_issue_val_b   = '0;
    out_issue_dst_tag = '0;
    out_issue_set_cc  = 1'b0;
    if (out_issue_valid) begin
      out_issue_alu_op  = ent_q[sel_idx].alu_op;
      out_issue_val_a   = ent_q[sel_idx].val_a;
      out_issue_val_b   = ent_q[sel_idx].val_b;
      out_issue_dst_tag = ent_q[sel_idx].dst_tag;
      out_issue_set_cc  = ent_q[sel_idx].set_cc;
    end
  end

  assign cdb_hit_a = in_cdb_valid && (in_disp_tag_a == in_cdb_tag);
  assign cdb_hit_b = in_cdb_valid && (in_disp_tag_b == in_cdb_tag);

  // New entry, including same-cycle CDB forwarding for operands not ready at dispatch.
  always_comb begin
    disp_ent         = '0;
    disp_ent.valid   = 1'b1;
    disp_ent.alu_op  = in_disp_alu_op;
    disp_ent.set_cc  = in_disp_set_cc;
    disp_ent.dst_tag = in_disp_dst_tag;
    disp_ent.tag_a   = in_disp_tag_a;
    disp_ent.rdy_a   = in_disp_rdy_a || cdb_hit_a;
    disp_ent.val_a   = (!in_disp_rdy_a && cdb_hit_a) ? in_cdb_val : in_disp_val_a;
    if (!in_disp_valb_sel) begin
      disp_ent.rdy_b = 1'b1;
      disp_ent.val_b = in_disp_imm;
    end else begin
      disp_ent.tag_b = in_disp_tag_b;
      disp_ent.rdy_b = in_disp_rdy_b || cdb_hit_b;
      disp_ent.val_b = (!in_disp_rdy_b && cdb_hit_b) ? in_cdb_val : in_disp_val_b;
    end
  end

  assign disp_fire = in_disp_valid && out_disp_ready && !in_flush;

  always_comb begin
    ent_d = ent_q;
    if (in_flush) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ent_d[i].valid = 1'b0;
      end
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (ent_q[i].valid && in_cdb_valid) begin
          if (!ent_q[i].rdy_a && (ent_q[i].tag_a == in_cdb_tag)) begin
            ent_d[i].rdy_a = 1'b1;
            ent_d[i].val_a = in_cdb_val;
          end
          if (!ent_q[i].rdy_b && (ent_q[i].tag_b == in_cdb_tag)) begin
            ent_d[i].rdy_b = 1'b1;
            ent_d[i].val_b = in_cdb_val;
          end
        end
      end
      if (out_issue_valid && in_issue_ready) begin
        ent_d[sel_idx].valid = 1'b0;
      end
      // Free slot comes from registered valid bits, so it never aliases the issuing slot.
      if (disp_fire) begin
        ent_d[free_idx] = disp_ent;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station with hand-computed expectations.
module tb_alu_reservation_station;
  import alu_rs_pkg::*;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic        in_flush;
  logic        in_disp_valid;
  logic        out_disp_ready;
  alu_op_t     in_disp_alu_op;
  logic        in_disp_set_cc;
  logic        in_disp_valb_sel;
  logic [63:0] in_disp_imm;
  logic        in_disp_rdy_a, in_disp_rdy_b;
  logic [63:0] in_disp_val_a, in_disp_val_b;
  logic [3:0]  in_disp_tag_a, in_disp_tag_b, in_disp_dst_tag;
  logic        in_cdb_valid;
  logic [3:0]  in_cdb_tag;
  logic [63:0] in_cdb_val;
  logic        out_issue_valid;
  logic        in_issue_ready;
  alu_op_t     out_issue_alu_op;
  logic [63:0] out_issue_val_a, out_issue_val_b;
  logic [3:0]  out_issue_dst_tag;
  logic        out_issue_set_cc;

  int n_checks = 0;
  int n_errors = 0;

  alu_reservation_station #(.ENTRIES(4), .TAG_W(4), .DATA_W(64)) dut (
    .in_clk            (in_clk),
    .in_rst_n          (in_rst_n),
    .in_flush          (in_flush),
    .in_disp_valid     (in_disp_valid),
    .out_disp_ready    (out_disp_ready),
    .in_disp_alu_op    (in_disp_alu_op),
    .in_disp_set_cc    (in_disp_set_cc),
    .in_disp_valb_sel  (in_disp_valb_sel),
    .in_disp_imm       (in_disp_imm),
    .in_disp_rdy_a     (in_disp_rdy_a),
    .in_disp_rdy_b     (in_disp_rdy_b),
    .in_disp_val_a     (in_disp_val_a),
    .in_disp_val_b     (in_disp_val_b),
    .in_disp_tag_a     (in_disp_tag_a),
    .in_disp_tag_b     (in_disp_tag_b),
    .in_disp_dst_tag   (in_disp_dst_tag),
    .in_cdb_valid      (in_cdb_valid),
    .in_cdb_tag        (in_cdb_tag),
    .in_cdb_val        (in_cdb_val),
    .out_issue_valid   (out_issue_valid),
    .in_issue_ready    (in_issue_ready),
    .out_issue_alu_op  (out_issue_alu_op),
    .out_issue_val_a   (out_issue_val_a),
    .out_issue_val_b   (out_issue_val_b),
    .out_issue_dst_tag (out_issue_dst_tag),
    .out_issue_set_cc  (out_issue_set_cc)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1; outputs are looked at 2ns later, well before the next edge.
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic idle();
    in_flush       = 1'b0;
    in_disp_valid  = 1'b0;
    in_disp_alu_op = AluPlus;
    in_disp_set_cc = 1'b0;
    in_disp_valb_sel = 1'b1;
    in_disp_imm    = '0;
    in_disp_rdy_a  = 1'b0;
    in_disp_rdy_b  = 1'b0;
    in_disp_val_a  = '0;
    in_disp_val_b  = '0;
    in_disp_tag_a  = '0;
    in_disp_tag_b  = '0;
    in_disp_dst_tag = '0;
    in_cdb_valid   = 1'b0;
    in_cdb_tag     = '0;
    in_cdb_val     = '0;
  endtask

  task automatic disp(input alu_op_t op, input logic cc, input logic vsel, input logic [63:0] imm,
                      input logic ra, input logic [63:0] va, input logic [3:0] ta,
                      input logic rb, input logic [63:0] vb, input logic [3:0] tb,
                      input logic [3:0] dst);
    in_disp_valid    = 1'b1;
    in_disp_alu_op   = op;
    in_disp_set_cc   = cc;
    in_disp_valb_sel = vsel;
    in_disp_imm      = imm;
    in_disp_rdy_a    = ra;
    in_disp_val_a    = va;
    in_disp_tag_a    = ta;
    in_disp_rdy_b    = rb;
    in_disp_val_b    = vb;
    in_disp_tag_b    = tb;
    in_disp_dst_tag  = dst;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [63:0] val);
    in_cdb_valid = 1'b1;
    in_cdb_tag   = tag;
    in_cdb_val   = val;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_issue_valid), 64'd0);
    check({tag, "_op"}, 64'(out_issue_alu_op), 64'd0);
    check({tag, "_a"}, out_issue_val_a, 64'd0);
    check({tag, "_b"}, out_issue_val_b, 64'd0);
    check({tag, "_dst"}, 64'(out_issue_dst_tag), 64'd0);
    check({tag, "_cc"}, 64'(out_issue_set_cc), 64'd0);
  endtask

  initial begin
    idle();
    in_issue_ready = 1'b0;
    in_rst_n = 1'b0;
    #3;
    check("rst_disp_ready", 64'(out_disp_ready), 64'd1);
    check_idle_outputs("rst");
    #10 in_rst_n = 1'b1;
    tick();

    // Basic: both operands ready, issue one cycle after dispatch.
    in_issue_ready = 1'b1;
    disp(AluPlus, 1'b0, 1'b1, 64'd0, 1'b1, 64'd5, 4'd0, 1'b1, 64'd7, 4'd0, 4'd3);
    look();
    check("basic_not_yet", 64'(out_issue_valid), 64'd0);
    tick(); idle(); look();
    check("basic_valid", 64'(out_issue_valid), 64'd1);
    check("basic_a", out_issue_val_a, 64'd5);
    check("basic_b", out_issue_val_b, 64'd7);
    check("basic_dst", 64'(out_issue_dst_tag), 64'd3);
    check("basic_op", 64'(out_issue_alu_op), 64'(AluPlus));
    tick(); look();
    check("basic_gone", 64'(out_issue_valid), 64'd0);

    // Immediate B: rdy_b/tag_b ignored.
    disp(AluMinus, 1'b1, 1'b0, 64'h10, 1'b1, 64'd1, 4'd0, 1'b0, 64'd0, 4'd9, 4'd4);
    tick(); idle(); look();
    check("imm_valid", 64'(out_issue_valid), 64'd1);
    check("imm_b", out_issue_val_b, 64'h10);
    check("imm_cc", 64'(out_issue_set_cc), 64'd1);
    check("imm_op", 64'(out_issue_alu_op), 64'(AluMinus));
    check("imm_dst", 64'(out_issue_dst_tag), 64'd4);
    tick(); look();
    check("imm_gone", 64'(out_issue_valid), 64'd0);

    // Wakeup: A waits on tag 2.
    disp(AluAnd, 1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 4'd2, 1'b1, 64'd1, 4'd0, 4'd5);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      look();
      check("wake_wait", 64'(out_issue_valid), 64'd0);
      tick();
    end
    cdb(4'd2, 64'hAB);
    look();
    check("wake_no_bypass", 64'(out_issue_valid), 64'd0);
    tick(); idle(); look();
    check("wake_valid", 64'(out_issue_valid), 64'd1);
    check("wake_a", out_issue_val_a, 64'hAB);
    check("wake_dst", 64'(out_issue_dst_tag), 64'd5);
    tick(); look();
    check("wake_gone", 64'(out_issue_valid), 64'd0);

    // Same-cycle forwarding at dispatch.
    disp(AluXor, 1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 4'd2, 1'b1, 64'd2, 4'd0, 4'd6);
    cdb(4'd2, 64'hCD);
    tick(); idle(); look();
    check("fwd_valid", 64'(out_issue_valid), 64'd1);
    check("fwd_a", out_issue_val_a, 64'hCD);
    check("fwd_dst", 64'(out_issue_dst_tag), 64'd6);
    tick(); look();
    check("fwd_gone", 64'(out_issue_valid), 64'd0);

    // Full / backpressure: slots 0..3 wait on tags 10..13, dst = slot index.
    in_issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(AluPlus, 1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 4'(10 + i), 1'b1, 64'(i), 4'd0, 4'(i));
      tick();
    end
    idle(); look();
    check("full_ready", 64'(out_disp_ready), 64'd0);
    disp(AluPlus, 1'b0, 1'b1, 64'd0, 1'b1, 64'd1, 4'd0, 1'b1, 64'd1, 4'd0, 4'd7);
    tick(); idle(); look();
    check("full_drop", 64'(out_issue_valid), 64'd0);
    check("full_ready2", 64'(out_disp_ready), 64'd0);
    cdb(4'd12, 64'h22);
    tick(); idle();
    for (int i = 0; i < 2; i++) begin
      look();
      check("hold_valid", 64'(out_issue_valid), 64'd1);
      check("hold_dst", 64'(out_issue_dst_tag), 64'd2);
      check("hold_a", out_issue_val_a, 64'h22);
      tick();
    end
    in_issue_ready = 1'b1;
    look();
    check("release_dst", 64'(out_issue_dst_tag), 64'd2);
    check("release_ready_same", 64'(out_disp_ready), 64'd0);
    tick(); look();
    check("release_ready_next", 64'(out_disp_ready), 64'd1);
    check("release_empty_issue", 64'(out_issue_valid), 64'd0);

    // Flush with slots 0,1,3 valid plus simultaneous dispatch and CDB.
    in_flush = 1'b1;
    disp(AluPlus, 1'b0, 1'b1, 64'd0, 1'b1, 64'd9, 4'd0, 1'b1, 64'd9, 4'd0, 4'd8);
    cdb(4'd10, 64'h99);
    look();
    check("flush_issue", 64'(out_issue_valid), 64'd0);
    tick(); idle(); look();
    check("flush_after_issue", 64'(out_issue_valid), 64'd0);
    check("flush_after_ready", 64'(out_disp_ready), 64'd1);
    cdb(4'd11, 64'h1);
    tick(); idle(); cdb(4'd13, 64'h1);
    tick(); idle(); look();
    check("flush_empty", 64'(out_issue_valid), 64'd0);

    // Priority: slots 1 and 3 both wait on tag 5.
    in_issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(AluPlus, 1'b0, 1'b1, 64'd0, 1'b0, 64'd0, (i == 0) ? 4'd6 : (i == 2) ? 4'd7 : 4'd5,
           1'b1, 64'd0, 4'd0, 4'(i));
      tick();
    end
    idle();
    in_issue_ready = 1'b1;
    cdb(4'd5, 64'h55);
    look();
    check("prio_none_yet", 64'(out_issue_valid), 64'd0);
    tick(); idle(); look();
    check("prio_first_valid", 64'(out_issue_valid), 64'd1);
    check("prio_first_dst", 64'(out_issue_dst_tag), 64'd1);
    check("prio_first_a", out_issue_val_a, 64'h55);
    tick();
    // Slot 3 issues while a ready op dispatches into the slot 1 just freed.
    disp(AluXor, 1'b0, 1'b1, 64'd0, 1'b1, 64'h31, 4'd0, 1'b1, 64'h32, 4'd0, 4'd9);
    look();
    check("prio_second_dst", 64'(out_issue_dst_tag), 64'd3);
    check("prio_disp_ready", 64'(out_disp_ready), 64'd1);
    tick(); idle(); look();
    check("simul_valid", 64'(out_issue_valid), 64'd1);
    check("simul_dst", 64'(out_issue_dst_tag), 64'd9);
    check("simul_b", out_issue_val_b, 64'h32);
    tick(); look();
    check("simul_gone", 64'(out_issue_valid), 64'd0);

    // Async reset mid-cycle while slot 0 is issuable and held.
    in_issue_ready = 1'b0;
    cdb(4'd6, 64'h66);
    tick(); idle(); look();
    check("arst_pre_valid", 64'(out_issue_valid), 64'd1);
    check("arst_pre_dst", 64'(out_issue_dst_tag), 64'd0);
    check("arst_pre_a", out_issue_val_a, 64'h66);
    in_rst_n = 1'b0;
    #1;
    check_idle_outputs("arst");
    check("arst_disp_ready", 64'(out_disp_ready), 64'd1);
    tick();
    in_rst_n = 1'b1;
    cdb(4'd7, 64'h77);
    tick(); idle(); look();
    check("arst_empty", 64'(out_issue_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
